// File: rtl/quad_decoder_pkg.sv
// Shared types and transition tables for the quadrature decoder.
package quad_decoder_pkg;

  // Filtered phase pair, packed as {A, B}.
  typedef logic [1:0] phase_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Next-state tables, indexed by the current phase pair (2 bits per entry).
  // Up:   00->01, 01->11, 11->10, 10->00
  // Down: 00->10, 10->11, 11->01, 01->00
  localparam logic [7:0] UP_TABLE   = 8'b10_00_11_01;
  localparam logic [7:0] DOWN_TABLE = 8'b01_11_00_10;

  function automatic phase_t up_next(input phase_t p);
    return UP_TABLE[{p, 1'b0} +: 2];
  endfunction

  function automatic phase_t down_next(input phase_t p);
    return DOWN_TABLE[{p, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_decoder_counter_if.sv
// Encoder-side inputs and position outputs of the quadrature decoder.
interface quad_decoder_counter_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             clr_err;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             dir;
  logic             err;

  // Driver of the encoder phases and control, consumer of the position.
  modport master (
    output enc_a, enc_b, load, load_data, clr_err,
    input  count, step, dir, err
  );

  // The decoder itself.
  modport slave (
    input  enc_a, enc_b, load, load_data, clr_err,
    output count, step, dir, err
  );
endinterface

// File: rtl/qd_input_filter.sv
// Synchroniser plus deglitch filter for one asynchronous encoder phase.
module qd_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CW-1:0]          r_cnt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_level  = r_level;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (w_synced == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_level <= w_synced;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder: filters A/B, decodes Gray steps, keeps a loadable position.
module quad_decoder_counter
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  quad_decoder_counter_if.slave bus
);

  // Decoding is held off until the filters have had time to pass the pin
  // levels present at reset; prev tracks the filtered pair meanwhile, so an
  // encoder resting at 11 never looks like a 00->11 jump.
  localparam int PRIME_CYC = SYNC_STAGES + FILT_LEN + 1;
  localparam int PW        = $clog2(PRIME_CYC + 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYC - 1);

  logic             w_a_filt;
  logic             w_b_filt;
  phase_t           w_cur;
  logic             w_up;
  logic             w_down;
  logic             w_illegal;

  phase_t           r_prev;
  logic             r_primed;
  logic [PW-1:0]    r_prime_cnt;
  logic [WIDTH-1:0] r_count;
  logic             r_step;
  logic             r_dir;
  logic             r_err;

  qd_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_raw  (bus.enc_a),
    .o_level(w_a_filt)
  );

  qd_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_raw  (bus.enc_b),
    .o_level(w_b_filt)
  );

  assign w_cur     = {w_a_filt, w_b_filt};
  assign w_up      = r_primed && (w_cur == up_next(r_prev));
  assign w_down    = r_primed && (w_cur == down_next(r_prev));
  assign w_illegal = r_primed && (w_cur == ~r_prev);

  assign bus.count = r_count;
  assign bus.step  = r_step;
  assign bus.dir   = r_dir;
  assign bus.err   = r_err;

  // Track the previous filtered pair and the priming window after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_primed    <= 1'b0;
      r_prime_cnt <= '0;
    end else begin
      r_prev <= w_cur;
      if (!r_primed) begin
        if (r_prime_cnt == PRIME_LAST) r_primed    <= 1'b1;
        else                           r_prime_cnt <= r_prime_cnt + PW'(1);
      end
    end
  end

  // Step pulse and direction follow every valid transition, loaded or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= 1'b0;
      r_dir  <= DIR_DOWN;
    end else begin
      r_step <= w_up || w_down;
      if (w_up)        r_dir <= DIR_UP;
      else if (w_down) r_dir <= DIR_DOWN;
    end
  end

  // Position: load overrides decode; wraps modulo 2^WIDTH.
  always_ff @(posedge clk) begin
    if (rst)         r_count <= '0;
    else if (bus.load) r_count <= bus.load_data;
    else if (w_up)   r_count <= r_count + WIDTH'(1);
    else if (w_down) r_count <= r_count - WIDTH'(1);
  end

  // Sticky illegal-transition flag; a new error beats a clear.
  always_ff @(posedge clk) begin
    if (rst)              r_err <= 1'b0;
    else if (w_illegal)   r_err <= 1'b1;
    else if (bus.clr_err) r_err <= 1'b0;
  end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter (WIDTH=8, SYNC_STAGES=2, FILT_LEN=3).
module tb_quad_decoder_counter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int unsigned step_total;
  int unsigned snap;

  quad_decoder_counter_if #(.WIDTH(8)) bus ();

  quad_decoder_counter #(.WIDTH(8), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running total of step pulses, sampled mid-cycle.
  initial step_total = 0;
  always @(negedge clk) if (bus.step === 1'b1) step_total++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pins(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pins(2'b11);
    tick(2);
    n_cmp++; if (bus.count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want %h", bus.count, 8'h00); end
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %b want 0", bus.step); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", bus.dir); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    rst = 1'b0;
    snap = step_total;
    tick(10);
    n_cmp++; if (step_total - snap !== 0) begin n_bad++; $display("FAIL rest11_steps: got %0d want 0", step_total - snap); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rest11_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.count !== 8'h00) begin n_bad++; $display("FAIL rest11_count: got %h want %h", bus.count, 8'h00); end
  endtask

  task automatic test_up();
    logic [1:0] seq [4];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    rst = 1'b1;
    set_pins(2'b00);
    tick(1);
    rst = 1'b0;
    tick(10);
    snap = step_total;
    for (int i = 0; i < 16; i++) begin
      set_pins(seq[(i + 1) % 4]);
      if (i == 0) begin
        tick(5);
        n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL latency_early: got step %b want 0", bus.step); end
        tick(1);
        n_cmp++; if (bus.step !== 1'b1) begin n_bad++; $display("FAIL latency_exact: got step %b want 1", bus.step); end
        tick(4);
      end else begin
        tick(10);
      end
    end
    n_cmp++; if (step_total - snap !== 16) begin n_bad++; $display("FAIL up_steps: got %0d want 16", step_total - snap); end
    n_cmp++; if (bus.count !== 8'h10) begin n_bad++; $display("FAIL up_count: got %h want %h", bus.count, 8'h10); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL up_dir: got %b want 1", bus.dir); end
  endtask

  task automatic test_wrap_down();
    bus.load_data = 8'h01;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.count !== 8'h01) begin n_bad++; $display("FAIL load_count: got %h want %h", bus.count, 8'h01); end
    set_pins(2'b10);
    tick(10);
    n_cmp++; if (bus.count !== 8'h00) begin n_bad++; $display("FAIL down1_count: got %h want %h", bus.count, 8'h00); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL down1_dir: got %b want 0", bus.dir); end
    set_pins(2'b11);
    tick(10);
    n_cmp++; if (bus.count !== 8'hFF) begin n_bad++; $display("FAIL wrap_count: got %h want %h", bus.count, 8'hFF); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL wrap_dir: got %b want 0", bus.dir); end
  endtask

  task automatic test_illegal();
    set_pins(2'b10);
    tick(10);
    set_pins(2'b00);
    tick(10);
    n_cmp++; if (bus.count !== 8'h01) begin n_bad++; $display("FAIL wrap_up_count: got %h want %h", bus.count, 8'h01); end
    set_pins(2'b11);
    tick(10);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.count !== 8'h01) begin n_bad++; $display("FAIL illegal_count: got %h want %h", bus.count, 8'h01); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL illegal_dir: got %b want 1", bus.dir); end
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b want 0", bus.err); end
    set_pins(2'b00);
    tick(5);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL pre_jump_err: got %b want 0", bus.err); end
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL set_beats_clr: got %b want 1", bus.err); end
    tick(4);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  task automatic test_glitch();
    snap = step_total;
    bus.enc_a = 1'b1;
    tick(2);
    bus.enc_a = 1'b0;
    tick(10);
    n_cmp++; if (step_total - snap !== 0) begin n_bad++; $display("FAIL glitch_steps: got %0d want 0", step_total - snap); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL glitch_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.count !== 8'h01) begin n_bad++; $display("FAIL glitch_count: got %h want %h", bus.count, 8'h01); end
  endtask

  task automatic test_load_step();
    set_pins(2'b10);
    tick(10);
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL pre_load_dir: got %b want 0", bus.dir); end
    set_pins(2'b00);
    tick(5);
    bus.load_data = 8'h80;
    bus.load = 1'b1;
    tick(1);
    bus.load = 1'b0;
    n_cmp++; if (bus.count !== 8'h80) begin n_bad++; $display("FAIL load_step_count: got %h want %h", bus.count, 8'h80); end
    n_cmp++; if (bus.step !== 1'b1) begin n_bad++; $display("FAIL load_step_pulse: got %b want 1", bus.step); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL load_step_dir: got %b want 1", bus.dir); end
    tick(1);
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL step_one_cycle: got %b want 0", bus.step); end
    tick(3);
  endtask

  task automatic test_mid_reset();
    set_pins(2'b11);
    tick(10);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL pre_rst_err: got %b want 1", bus.err); end
    set_pins(2'b10);
    tick(3);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (bus.count !== 8'h00) begin n_bad++; $display("FAIL midrst_count: got %h want %h", bus.count, 8'h00); end
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL midrst_step: got %b want 0", bus.step); end
    n_cmp++; if (bus.dir !== 1'b0) begin n_bad++; $display("FAIL midrst_dir: got %b want 0", bus.dir); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", bus.err); end
    rst = 1'b0;
    snap = step_total;
    tick(10);
    n_cmp++; if (step_total - snap !== 0) begin n_bad++; $display("FAIL reprime_steps: got %0d want 0", step_total - snap); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reprime_err: got %b want 0", bus.err); end
    set_pins(2'b00);
    tick(10);
    n_cmp++; if (bus.count !== 8'h01) begin n_bad++; $display("FAIL resume_count: got %h want %h", bus.count, 8'h01); end
    n_cmp++; if (bus.dir !== 1'b1) begin n_bad++; $display("FAIL resume_dir: got %b want 1", bus.dir); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL resume_err: got %b want 0", bus.err); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.load = 1'b0;
    bus.load_data = 8'h00;
    bus.clr_err = 1'b0;
    test_reset();
    test_up();
    test_wrap_down();
    test_illegal();
    test_glitch();
    test_load_step();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
